// File: rtl/shift_engine_pkg.sv
// rtl/shift_engine_pkg.sv - shared op/state encodings and default sizes for the multi-cycle shifter
package shift_engine_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int AMT_W_DEF = 4;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shift_engine_if.sv
// rtl/shift_engine_if.sv - start/done request bus between the controller and shift_engine
interface shift_engine_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
);
   logic             start;
   logic [WIDTH-1:0] in;
   logic [1:0]       shift;
   logic [AMT_W-1:0] amt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sout;

   modport master (
      output start, in, shift, amt,
      input  busy, done, sout
   );

   modport slave (
      input  start, in, shift, amt,
      output busy, done, sout
   );
endinterface

// File: rtl/shift_engine_step.sv
// rtl/shift_engine_step.sv - one single-bit shift step; op 00 rotates right only with SHIFT_ENGINE_ROR_EN
module shift_step
   import shift_engine_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = data;
      case (op)
         SH_LSL:  result = {data[WIDTH-2:0], 1'b0};
         SH_LSR:  result = {1'b0, data[WIDTH-1:1]};
         SH_ASR:  result = {data[WIDTH-1], data[WIDTH-1:1]};
`ifdef SHIFT_ENGINE_ROR_EN
         default: result = {data[0], data[WIDTH-1:1]};
`else
         default: result = data;
`endif
      endcase
   end

endmodule

// File: rtl/shift_engine.sv
// rtl/shift_engine.sv - multi-cycle variable-amount shifter, one bit per clock (op 00 rotate: SHIFT_ENGINE_ROR_EN)
module shift_engine
   import shift_engine_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AMT_W = AMT_W_DEF
) (
   input  logic          clk,
   input  logic          reset,
   shift_engine_if.slave bus
);

   state_t           state, state_nx;
   logic [WIDTH-1:0] data_q;
   logic [AMT_W-1:0] count_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] step_data;
   logic [AMT_W-1:0] eff_amt;
   logic             accept;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .data   (data_q),
      .op     (op_q),
      .result (step_data)
   );

   // Without the rotate option op 00 is a pass-through, so its count collapses to zero.
   always_comb begin
`ifdef SHIFT_ENGINE_ROR_EN
      eff_amt = bus.amt;
`else
      eff_amt = (bus.shift == SH_NONE) ? '0 : bus.amt;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            state_nx = ST_IDLE;
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = (eff_amt == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (count_q == AMT_W'(1)) state_nx = ST_DONE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         count_q <= '0;
         op_q    <= SH_NONE;
      end else if (accept) begin
         data_q  <= bus.in;
         count_q <= eff_amt;
         op_q    <= bus.shift;
      end else if (state == ST_SHIFT) begin
         data_q  <= step_data;
         count_q <= count_q - AMT_W'(1);
      end
   end

   assign bus.busy = (state == ST_SHIFT);
   assign bus.done = (state == ST_DONE);
   assign bus.sout = data_q;

endmodule

// File: tb/tb_shift_engine.sv
// tb/tb_shift_engine.sv - directed self-checking bench for shift_engine
module tb_shift_engine;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   shift_engine_if #(.WIDTH(16), .AMT_W(4)) bus ();

   shift_engine #(.WIDTH(16), .AMT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic issue(input logic [15:0] d, input logic [1:0] op, input logic [3:0] n);
      bus.start = 1'b1;
      bus.in    = d;
      bus.shift = op;
      bus.amt   = n;
      tick();
      bus.start = 1'b0;
      bus.in    = 16'h5A5A;
      bus.shift = 2'b00;
      bus.amt   = 4'hF;
   endtask

   // Count busy cycles (bounded) after acceptance, then check the done cycle.
   task automatic finish_op(input string tag, input int exp_busy, input logic [15:0] exp_sout);
      int busy_cnt;
      int overlap;
      busy_cnt = 0;
      overlap  = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.busy && bus.done) overlap++;
         if (!bus.busy) break;
         busy_cnt++;
         tick();
      end
      chk({tag, " busy_cycles"}, busy_cnt, exp_busy);
      chk({tag, " busy_done_overlap"}, overlap, 0);
      chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
      chk({tag, " sout"}, {16'd0, bus.sout}, {16'd0, exp_sout});
   endtask

   initial begin
      int seen_done;
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.in    = '0;
      bus.shift = '0;
      bus.amt   = '0;
      tick();
      tick();
      chk("reset sout", {16'd0, bus.sout}, 32'd0);
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      chk("reset done", {31'd0, bus.done}, 32'd0);
      reset = 1'b0;
      tick();

      issue(16'h0001, 2'b01, 4'd15);
      finish_op("lsl15", 15, 16'h8000);
      tick();
      chk("lsl15 done_clears", {31'd0, bus.done}, 32'd0);

      issue(16'h8004, 2'b11, 4'd2);
      finish_op("asr2", 2, 16'hE001);
      tick();
      issue(16'h8004, 2'b10, 4'd2);
      finish_op("lsr2", 2, 16'h2001);
      tick();

      issue(16'hABCD, 2'b10, 4'd0);
      finish_op("amt0", 0, 16'hABCD);
      tick();

      issue(16'h8000, 2'b11, 4'd15);
      finish_op("asr15", 15, 16'hFFFF);
      tick();
      issue(16'hFFFF, 2'b10, 4'd15);
      finish_op("lsr15", 15, 16'h0001);
      tick();

      // Back-to-back: a start during SHIFT is ignored, a start in DONE is taken.
      issue(16'h0010, 2'b01, 4'd3);
      chk("b2b busy", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'b1;
      bus.in    = 16'hFFFF;
      bus.shift = 2'b11;
      bus.amt   = 4'd5;
      tick();
      bus.start = 1'b0;
      finish_op("b2b first", 2, 16'h0080);
      issue(16'h0003, 2'b01, 4'd1);
      chk("b2b accepted_in_done", {31'd0, bus.busy}, 32'd1);
      tick();
      chk("b2b second done", {31'd0, bus.done}, 32'd1);
      chk("b2b second sout", {16'd0, bus.sout}, 32'h0006);
      tick();

`ifdef SHIFT_ENGINE_ROR_EN
      issue(16'h0001, 2'b00, 4'd4);
      finish_op("ror4", 4, 16'h1000);
`else
      issue(16'h0001, 2'b00, 4'd4);
      finish_op("none_pass", 0, 16'h0001);
`endif
      tick();

      issue(16'h0001, 2'b01, 4'd10);
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("abort sout", {16'd0, bus.sout}, 32'd0);
      chk("abort busy", {31'd0, bus.busy}, 32'd0);
      chk("abort done", {31'd0, bus.done}, 32'd0);
      tick();
      reset = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.done || bus.busy) seen_done++;
         tick();
      end
      chk("abort no_done", seen_done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
